// File: rtl/jogo_pkg.sv
// Shared game definitions: screen size, projectile FSM states and the box
// overlap test used by both enemy and player shot logic.
package jogo_pkg;

  localparam int LARGURA_TELA = 640;
  localparam int ALTURA_TELA  = 480;

  typedef enum logic [1:0] {ESPERA, VOO, ACERTO} estado_tiro_t;

  // Strict AABB overlap; callers zero-extend to 11 bits so sums never wrap.
  function automatic logic aabb_overlap(
    input logic [10:0] ax, ay, aw, ah,
    input logic [10:0] bx, by, bw, bh
  );
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

endpackage

// File: rtl/tiro_inimigo_gerador_tick.sv
// Movement tick divider: one-cycle pulse every DIV clocks, frozen by pausa.
module gerador_tick #(
  parameter int DIV = 2500000
) (
  input  logic CLOCK_50,
  input  logic resetInimigo,
  input  logic pausa,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = !pausa && (cnt_q == TERM);

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo)  cnt_q <= '0;
    else if (!pausa)   cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/tiro_inimigo.sv
// Enemy projectile engine: periodic downward shot, player hit detection.
// Define TIRO_INIMIGO_MIRA_EN to make the shot drift toward the player.
module tiro_inimigo
  import jogo_pkg::*;
#(
  parameter int TICK_DIV        = 2500000,
  parameter int PASSO           = 10,
  parameter int INTERVALO_TICKS = 40,
  parameter int LARG_TIRO       = 4,
  parameter int ALT_TIRO        = 10
) (
  input  logic       CLOCK_50,
  input  logic       resetInimigo,
  input  logic       pausa,
  input  logic [9:0] inimigo_x,
  input  logic [9:0] inimigo_y,
  input  logic [9:0] inimigo_largura,
  input  logic [9:0] inimigo_altura,
  input  logic       inimigo_vivo,
  input  logic [9:0] jogador_x,
  input  logic [9:0] jogador_y,
  input  logic [9:0] jogador_largura,
  input  logic [9:0] jogador_altura,
  input  logic       acerto_ack,
  output logic [9:0] tiro_x,
  output logic [9:0] tiro_y,
  output logic [9:0] tiro_largura,
  output logic [9:0] tiro_altura,
  output logic       tiro_ativo,
  output logic       acerto
);

  localparam int CW = (INTERVALO_TICKS > 1) ? $clog2(INTERVALO_TICKS) : 1;
  localparam logic [CW-1:0] INT_TERM = CW'(INTERVALO_TICKS - 1);
  localparam logic [10:0]   MEIA_L   = 11'(LARG_TIRO / 2);

  estado_tiro_t  estado_q;
  logic [CW-1:0] cnt_int_q;
  logic [9:0]    tiro_x_q, tiro_y_q;
  logic          tiro_ativo_q, acerto_q;

  logic          tick;
  logic [10:0]   centro, y_next;
  logic [9:0]    lanc_x_d, lanc_y_d, tiro_x_d;
  logic          sobrepoe;

  gerador_tick #(.DIV(TICK_DIV)) u_tick (
    .CLOCK_50    (CLOCK_50),
    .resetInimigo(resetInimigo),
    .pausa       (pausa),
    .tick        (tick)
  );

  always_comb begin
    centro   = {1'b0, inimigo_x} + ({1'b0, inimigo_largura} >> 1);
    lanc_x_d = (centro < MEIA_L) ? '0 : 10'(centro - MEIA_L);
    lanc_y_d = inimigo_y + inimigo_altura;
    y_next   = {1'b0, tiro_y_q} + 11'(PASSO);
    sobrepoe = aabb_overlap({1'b0, tiro_x_q}, {1'b0, tiro_y_q}, 11'(LARG_TIRO), 11'(ALT_TIRO),
                            {1'b0, jogador_x}, {1'b0, jogador_y},
                            {1'b0, jogador_largura}, {1'b0, jogador_altura});
  end

`ifdef TIRO_INIMIGO_MIRA_EN
  localparam logic [10:0] X_MAX = 11'(LARGURA_TELA - LARG_TIRO);
  logic [10:0] alvo_sum, alvo, tx, tx_n;

  // Step 2 px toward the player's centre, landing exactly on it.
  always_comb begin
    alvo_sum = {1'b0, jogador_x} + ({1'b0, jogador_largura} >> 1);
    alvo     = (alvo_sum < MEIA_L) ? '0 : alvo_sum - MEIA_L;
    if (alvo > X_MAX) alvo = X_MAX;
    tx   = {1'b0, tiro_x_q};
    tx_n = tx;
    if (tx < alvo)      tx_n = (alvo - tx >= 11'd2) ? tx + 11'd2 : alvo;
    else if (tx > alvo) tx_n = (tx - alvo >= 11'd2) ? tx - 11'd2 : alvo;
    if (tx_n > X_MAX)   tx_n = X_MAX;
    tiro_x_d = tx_n[9:0];
  end
`else
  always_comb tiro_x_d = tiro_x_q;
`endif

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      estado_q     <= ESPERA;
      cnt_int_q    <= '0;
      tiro_x_q     <= '0;
      tiro_y_q     <= '0;
      tiro_ativo_q <= 1'b0;
      acerto_q     <= 1'b0;
    end else begin
      case (estado_q)
        ESPERA: if (tick) begin
          // Saturate at the terminal count until the enemy is alive.
          if (cnt_int_q != INT_TERM) cnt_int_q <= cnt_int_q + 1'b1;
          else if (inimigo_vivo) begin
            tiro_x_q     <= lanc_x_d;
            tiro_y_q     <= lanc_y_d;
            cnt_int_q    <= '0;
            tiro_ativo_q <= 1'b1;
            estado_q     <= VOO;
          end
        end
        VOO: begin
          if (sobrepoe) begin
            estado_q     <= ACERTO;
            acerto_q     <= 1'b1;
            tiro_ativo_q <= 1'b0;
          end else if (tick) begin
            if (y_next >= 11'(ALTURA_TELA)) begin
              estado_q     <= ESPERA;
              tiro_ativo_q <= 1'b0;
            end else begin
              tiro_y_q <= y_next[9:0];
              tiro_x_q <= tiro_x_d;
            end
          end
        end
        ACERTO: if (acerto_ack) begin
          estado_q  <= ESPERA;
          acerto_q  <= 1'b0;
          cnt_int_q <= '0;
        end
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign tiro_x       = tiro_x_q;
  assign tiro_y       = tiro_y_q;
  assign tiro_largura = 10'(LARG_TIRO);
  assign tiro_altura  = 10'(ALT_TIRO);
  assign tiro_ativo   = tiro_ativo_q;
  assign acerto       = acerto_q;

endmodule

// File: tb/tb_tiro_inimigo.sv
// Scoreboarded bench for tiro_inimigo: each expected output change carries
// the cycle on which it must appear; the monitor pops on every change.
module tb_tiro_inimigo;

  logic       CLOCK_50 = 1'b0;
  logic       resetInimigo = 1'b0;
  logic       pausa = 1'b0, inimigo_vivo = 1'b1, acerto_ack = 1'b0;
  logic [9:0] inimigo_x = 10'd100, inimigo_y = 10'd50, inimigo_largura = 10'd30, inimigo_altura = 10'd30;
  logic [9:0] jogador_x = 10'd500, jogador_y = 10'd0, jogador_largura = 10'd20, jogador_altura = 10'd20;
  logic [9:0] tiro_x, tiro_y, tiro_largura, tiro_altura;
  logic       tiro_ativo, acerto;

  always #5 CLOCK_50 = ~CLOCK_50;

  tiro_inimigo #(.TICK_DIV(4), .PASSO(10), .INTERVALO_TICKS(3), .LARG_TIRO(4), .ALT_TIRO(10)) dut (
    .CLOCK_50(CLOCK_50), .resetInimigo(resetInimigo), .pausa(pausa),
    .inimigo_x(inimigo_x), .inimigo_y(inimigo_y), .inimigo_largura(inimigo_largura),
    .inimigo_altura(inimigo_altura), .inimigo_vivo(inimigo_vivo),
    .jogador_x(jogador_x), .jogador_y(jogador_y), .jogador_largura(jogador_largura),
    .jogador_altura(jogador_altura), .acerto_ack(acerto_ack),
    .tiro_x(tiro_x), .tiro_y(tiro_y), .tiro_largura(tiro_largura), .tiro_altura(tiro_altura),
    .tiro_ativo(tiro_ativo), .acerto(acerto)
  );

  typedef struct {
    string      nm;
    logic [21:0] v;
    int         at;
  } exp_t;

  exp_t        sb[$];
  logic [21:0] exp_cur = '0;
  logic [21:0] prev = '0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          R = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: any change of {ativo, acerto, x, y} must match the next expectation.
  always @(negedge CLOCK_50) begin
    logic [21:0] cur;
    exp_t e;
    cur = {tiro_ativo, acerto, tiro_x, tiro_y};
    if (cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got ativo=%0b acerto=%0b x=%0d y=%0d at cycle %0d, no change required",
                 cur[21], cur[20], cur[19:10], cur[9:0], cyc);
      end else begin
        e = sb.pop_front();
        if (cur !== e.v || cyc != e.at) begin
          errors++;
          $display("FAIL %s: got ativo=%0b acerto=%0b x=%0d y=%0d @%0d, required ativo=%0b acerto=%0b x=%0d y=%0d @%0d",
                   e.nm, cur[21], cur[20], cur[19:10], cur[9:0], cyc,
                   e.v[21], e.v[20], e.v[19:10], e.v[9:0], e.at);
        end
      end
      prev = cur;
    end
  end

  task automatic expect_state(input string nm, input logic a, input logic h,
                              input int x, input int y, input int at);
    logic [21:0] v;
    exp_t e;
    v = {a, h, 10'(x), 10'(y)};
    if (v != exp_cur) begin
      e.nm = nm; e.v = v; e.at = at;
      sb.push_back(e);
      exp_cur = v;
    end
  endtask

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic do_reset;
    @(posedge CLOCK_50); #2;
    resetInimigo = 1'b1;
    expect_state("reset", 0, 0, 0, 0, cyc);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #2;
    resetInimigo = 1'b0;
    R = cyc;
  endtask

  initial begin
    #1 resetInimigo = 1'b1;
    #1;
    chk("rst_ativo", int'(tiro_ativo), 0);
    chk("rst_acerto", int'(acerto), 0);
    chk("rst_x", int'(tiro_x), 0);
    chk("rst_y", int'(tiro_y), 0);
    chk("larg_const", int'(tiro_largura), 4);
    chk("alt_const", int'(tiro_altura), 10);
    @(posedge CLOCK_50); #2;
    resetInimigo = 1'b0;
    R = cyc;

    // Launch position and steady descent; ack is ignored outside ACERTO.
    acerto_ack = 1'b1;
    expect_state("launch", 1, 0, 113, 80, R + 12);
    expect_state("tick_y90", 1, 0, 113, 90, R + 16);
    expect_state("tick_y100", 1, 0, 113, 100, R + 20);
    wait_until(R + 21);
    acerto_ack = 1'b0;

    // Exit off the bottom, then a fresh launch INTERVALO ticks later.
    inimigo_y = 10'd440;
    do_reset;
    expect_state("launch_low", 1, 0, 113, 470, R + 12);
    expect_state("exit", 0, 0, 113, 470, R + 16);
    expect_state("relaunch", 1, 0, 113, 470, R + 28);
    wait_until(R + 30);

    // Hit, held 50 cycles, then acknowledged.
    inimigo_y = 10'd50;
    jogador_x = 10'd110; jogador_y = 10'd95; jogador_largura = 10'd30; jogador_altura = 10'd20;
    do_reset;
    expect_state("launch_hit", 1, 0, 113, 80, R + 12);
    expect_state("pre_hit", 1, 0, 113, 90, R + 16);
    expect_state("hit", 0, 1, 113, 90, R + 17);
    wait_until(R + 67);
    acerto_ack = 1'b1;
    expect_state("ack", 0, 0, 113, 90, R + 68);
    wait_until(R + 68);
    acerto_ack = 1'b0;
    wait_until(R + 70);

    // Pause for 100 cycles mid-flight: tick phase resumes where it froze.
    jogador_x = 10'd500; jogador_y = 10'd0; jogador_largura = 10'd20; jogador_altura = 10'd20;
    do_reset;
    expect_state("launch_p", 1, 0, 113, 80, R + 12);
    expect_state("pause_resume", 1, 0, 113, 90, R + 116);
    wait_until(R + 14);
    pausa = 1'b1;
    wait_until(R + 114);
    pausa = 1'b0;
    wait_until(R + 117);

    // Vivo gating through terminal count, and left-edge clamp.
    inimigo_x = 10'd0; inimigo_largura = 10'd2; inimigo_vivo = 1'b0;
    do_reset;
    wait_until(R + 21);
    inimigo_vivo = 1'b1;
    expect_state("clamp_launch", 1, 0, 0, 80, R + 24);
    wait_until(R + 26);

    // Asynchronous reset while in ACERTO.
    inimigo_x = 10'd100; inimigo_largura = 10'd30;
    jogador_x = 10'd110; jogador_y = 10'd95; jogador_largura = 10'd30; jogador_altura = 10'd20;
    do_reset;
    expect_state("launch_r", 1, 0, 113, 80, R + 12);
    expect_state("pre_hit_r", 1, 0, 113, 90, R + 16);
    expect_state("hit_r", 0, 1, 113, 90, R + 17);
    wait_until(R + 20);
    resetInimigo = 1'b1;
    expect_state("async_reset", 0, 0, 0, 0, cyc);
    #1;
    chk("async_acerto", int'(acerto), 0);
    chk("async_ativo", int'(tiro_ativo), 0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #2;
    resetInimigo = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #2;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation reached time limit, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
